psg_access_sched: RTL and testbench

PSG_ACCESS_SCHED -- requirements
Module: psg_access_sched

---
 rtl/psg_pkg.sv | 24 ++
 rtl/psg_bus_mux.sv | 46 ++++
 rtl/psg_access_sched.sv | 153 +++++++++++++++
 tb/tb_psg_access_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// psg_pkg: shared definitions for the PSG access scheduler.
//   - psg_state_t   : aux-port sequencer states
//   - PSG_SEL_ADDR  : bus address of the PSG register-select latch
//   - PSG_DATA_ADDR : bus address of the PSG register-data port
//   - register indices of the PSG register file
package psg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_DATA    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_DONE    = 3'd4
  } psg_state_t;

  localparam logic [7:0] PSG_SEL_ADDR  = 8'h00;
  localparam logic [7:0] PSG_DATA_ADDR = 8'h02;

  localparam logic [3:0] TONE_A_FINE = 4'd0;
  localparam logic [3:0] MIXER       = 4'd7;
  localparam logic [3:0] PORT_A      = 4'd14;
  localparam logic [3:0] PORT_B      = 4'd15;

endpackage

// File: rtl/psg_bus_mux.sv
// psg_bus_mux: combinational owner selection for the PSG bus.
//   cpu_act            : CPU owns the bus; cpu_* pass straight through
//   cpu_sel/ds/rw/addr/din : CPU bus strobes and payload
//   fsm_drive          : sequencer owns the bus when the CPU is quiet
//   fsm_rw/addr/din    : sequencer bus cycle (always selected, ds low)
//   psg_sel/ds/rw/addr/din : resulting PSG bus; idle pattern when nobody drives
module psg_bus_mux (
  input  logic       cpu_act,
  input  logic       cpu_sel,
  input  logic       cpu_ds,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       fsm_drive,
  input  logic       fsm_rw,
  input  logic [7:0] fsm_addr,
  input  logic [7:0] fsm_din,
  output logic       psg_sel,
  output logic       psg_ds,
  output logic       psg_rw,
  output logic [7:0] psg_addr,
  output logic [7:0] psg_din
);

  always_comb begin
    psg_sel  = 1'b0;
    psg_ds   = 1'b1;
    psg_rw   = 1'b1;
    psg_addr = 8'h00;
    psg_din  = 8'h00;
    if (cpu_act) begin
      psg_sel  = cpu_sel;
      psg_ds   = cpu_ds;
      psg_rw   = cpu_rw;
      psg_addr = cpu_addr;
      psg_din  = cpu_din;
    end else if (fsm_drive) begin
      psg_sel  = 1'b1;
      psg_ds   = 1'b0;
      psg_rw   = fsm_rw;
      psg_addr = fsm_addr;
      psg_din  = fsm_din;
    end
  end

endmodule

// File: rtl/psg_access_sched.sv
// psg_access_sched: shares one PSG bus between the CPU (always first) and an
// IO-controller aux port. An aux access is a select write, a data access and
// a select restore so the CPU's view of the select latch is left unchanged.
//   clk, reset_n        : clock, asynchronous active-low reset
//   cpu_sel/ds/rw/addr/din : CPU bus (ds active-low, rw=1 read)
//   aux_req/we/reg/wdata: aux request, held until aux_ack
//   aux_ack, aux_rdata  : completion pulse and read data
//   aux_busy            : sequencer not idle
//   aux_stalls          : saturating count of CPU-preempted cycles
//   psg_sel/ds/rw/addr/din, psg_dout : PSG bus
module psg_access_sched
  import psg_pkg::*;
#(
  parameter logic [7:0] SEL_ADDR  = PSG_SEL_ADDR,
  parameter logic [7:0] DATA_ADDR = PSG_DATA_ADDR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_sel,
  input  logic       cpu_ds,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic [3:0] aux_reg,
  input  logic [7:0] aux_wdata,
  output logic       aux_ack,
  output logic [7:0] aux_rdata,
  output logic       aux_busy,
  output logic [7:0] aux_stalls,
  output logic       psg_sel,
  output logic       psg_ds,
  output logic       psg_rw,
  output logic [7:0] psg_addr,
  output logic [7:0] psg_din,
  input  logic [7:0] psg_dout
);

  psg_state_t state, state_nxt;

  logic [3:0] lat_reg;
  logic       lat_we;
  logic [7:0] lat_wdata;
  logic [3:0] sel_shadow;

  logic       cpu_act;
  logic       cpu_sel_wr;
  logic       fsm_drive;
  logic       fsm_rw;
  logic [7:0] fsm_addr;
  logic [7:0] fsm_din;

  assign cpu_act    = cpu_sel & ~cpu_ds;
  assign cpu_sel_wr = cpu_act & ~cpu_rw & (cpu_addr == SEL_ADDR);
  assign aux_busy   = (state != ST_IDLE);

  // Next state and sequencer bus cycle
  always_comb begin
    state_nxt = state;
    fsm_drive = 1'b0;
    fsm_rw    = 1'b1;
    fsm_addr  = 8'h00;
    fsm_din   = 8'h00;

    // A CPU cycle voids the aux cycle; a CPU select write during the data
    // phase has moved the PSG latch, so the select must be re-issued.
    if (cpu_act) begin
      if (state == ST_DATA && cpu_sel_wr) state_nxt = ST_SEL;
    end else begin
      case (state)
        ST_IDLE:    if (aux_req) state_nxt = ST_SEL;
        ST_SEL:     state_nxt = ST_DATA;
        ST_DATA:    state_nxt = ST_RESTORE;
        ST_RESTORE: state_nxt = ST_DONE;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end

    case (state)
      ST_SEL: begin
        fsm_drive = 1'b1;
        fsm_rw    = 1'b0;
        fsm_addr  = SEL_ADDR;
        fsm_din   = {4'h0, lat_reg};
      end
      ST_DATA: begin
        fsm_drive = 1'b1;
        if (lat_we) begin
          fsm_rw   = 1'b0;
          fsm_addr = DATA_ADDR;
          fsm_din  = lat_wdata;
        end else begin
          fsm_rw   = 1'b1;
          fsm_addr = SEL_ADDR;
        end
      end
      ST_RESTORE: begin
        fsm_drive = 1'b1;
        fsm_rw    = 1'b0;
        fsm_addr  = SEL_ADDR;
        fsm_din   = {4'h0, sel_shadow};
      end
      default: ;
    endcase
  end

  // Registered control, request latch, shadow and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      aux_ack    <= 1'b0;
      aux_rdata  <= 8'h00;
      aux_stalls <= 8'h00;
      sel_shadow <= 4'h0;
      lat_reg    <= 4'h0;
      lat_we     <= 1'b0;
      lat_wdata  <= 8'h00;
    end else begin
      state <= state_nxt;
      // Pulse only on entry, so a CPU-held DONE still acks once.
      aux_ack <= (state_nxt == ST_DONE) && (state != ST_DONE);
      if (state == ST_IDLE && state_nxt == ST_SEL) begin
        lat_reg   <= aux_reg;
        lat_we    <= aux_we;
        lat_wdata <= aux_wdata;
      end
      if (state == ST_DATA && !cpu_act && !lat_we) aux_rdata <= psg_dout;
      if (cpu_sel_wr) sel_shadow <= cpu_din[3:0];
      if (cpu_act && aux_stalls != 8'hFF) aux_stalls <= aux_stalls + 8'd1;
    end
  end

  psg_bus_mux u_mux (
    .cpu_act   (cpu_act),
    .cpu_sel   (cpu_sel),
    .cpu_ds    (cpu_ds),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .fsm_drive (fsm_drive),
    .fsm_rw    (fsm_rw),
    .fsm_addr  (fsm_addr),
    .fsm_din   (fsm_din),
    .psg_sel   (psg_sel),
    .psg_ds    (psg_ds),
    .psg_rw    (psg_rw),
    .psg_addr  (psg_addr),
    .psg_din   (psg_din)
  );

endmodule

// File: tb/tb_psg_access_sched.sv
// Testbench for psg_access_sched: a behavioural PSG (select latch plus
// 16 registers) sits on the bus; expected bus cycles are queued as stimulus
// is applied and popped as the bus shows activity.
module tb_psg_access_sched;
  import psg_pkg::*;

  localparam logic [7:0] A_SEL  = 8'h00;
  localparam logic [7:0] A_DATA = 8'h02;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cpu_sel, cpu_ds, cpu_rw;
  logic [7:0] cpu_addr, cpu_din;
  logic       aux_req, aux_we;
  logic [3:0] aux_reg;
  logic [7:0] aux_wdata;
  logic       aux_ack, aux_busy;
  logic [7:0] aux_rdata, aux_stalls;
  logic       psg_sel, psg_ds, psg_rw;
  logic [7:0] psg_addr, psg_din, psg_dout;

  always #5 clk = ~clk;

  psg_access_sched dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_sel(cpu_sel), .cpu_ds(cpu_ds), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .aux_req(aux_req), .aux_we(aux_we), .aux_reg(aux_reg), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_busy(aux_busy), .aux_stalls(aux_stalls),
    .psg_sel(psg_sel), .psg_ds(psg_ds), .psg_rw(psg_rw),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_dout(psg_dout)
  );

  // Behavioural PSG
  logic [7:0] psg_regs [16] = '{default: 8'h00};
  logic [3:0] psg_latch = 4'h0;
  assign psg_dout = psg_regs[psg_latch];
  always @(posedge clk) begin
    if (psg_sel && !psg_ds && !psg_rw) begin
      if (psg_addr == A_SEL) psg_latch <= psg_din[3:0];
      else if (psg_addr == A_DATA) psg_regs[psg_latch] <= psg_din;
    end
  end

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] din;
    logic       chk_dout;
    logic [7:0] dout;
  } bus_t;
  bus_t exp_q[$];

  typedef struct packed {
    logic       we;
    logic       drop;
    logic [3:0] r;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{rw: 1'b0, addr: a, din: d, chk_dout: 1'b0, dout: 8'h00});
  endtask

  task automatic push_r(input logic [7:0] a, input logic chk, input logic [7:0] d);
    exp_q.push_back('{rw: 1'b1, addr: a, din: 8'h00, chk_dout: chk, dout: d});
  endtask

  task automatic cpu_idle();
    cpu_sel = 1'b0; cpu_ds = 1'b1; cpu_rw = 1'b1; cpu_addr = 8'h00; cpu_din = 8'h00;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    cpu_sel = 1'b1; cpu_ds = 1'b0; cpu_rw = 1'b1; cpu_addr = a; cpu_din = 8'h00;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_ds = 1'b0; cpu_rw = 1'b0; cpu_addr = a; cpu_din = d;
  endtask

  // One clock cycle: monitor the bus mid-cycle, then advance past the edge.
  task automatic step();
    bus_t e;
    @(negedge clk);
    if (psg_sel && !psg_ds) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bus_unexpected: got rw=%0d addr=%0h din=%0h, expected no cycle",
                 psg_rw, psg_addr, psg_din);
      end else begin
        e = exp_q.pop_front();
        check("bus_rw", 32'(psg_rw), 32'(e.rw));
        check("bus_addr", 32'(psg_addr), 32'(e.addr));
        if (!e.rw) check("bus_din", 32'(psg_din), 32'(e.din));
        if (e.rw && e.chk_dout) check("bus_dout", 32'(psg_dout), 32'(e.dout));
      end
    end else begin
      check("bus_idle", 32'({psg_sel, psg_ds, psg_rw, psg_addr, psg_din}),
            32'({1'b0, 1'b1, 1'b1, 8'h00, 8'h00}));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("rst_ack", 32'(aux_ack), 32'd0);
    check("rst_rdata", 32'(aux_rdata), 32'd0);
    check("rst_stalls", 32'(aux_stalls), 32'd0);
    check("rst_busy", 32'(aux_busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Runs one aux access; cpu read (at A_SEL) or cpu write happens in cycle c
  // when the matching mask bit is set. Cycle 0 is the request-sampling cycle.
  task automatic aux_txn(input logic we, input logic [3:0] r, input logic [7:0] wd,
                         input logic drop, input logic [31:0] rd_mask,
                         input logic [31:0] wr_mask, input logic [7:0] cw_data,
                         output int ack_cyc);
    aux_req = 1'b1; aux_we = we; aux_reg = r; aux_wdata = wd;
    ack_cyc = -1;
    for (int c = 0; c < 32 && ack_cyc < 0; c++) begin
      if (rd_mask[c]) cpu_read(A_SEL);
      else if (wr_mask[c]) cpu_write(A_SEL, cw_data);
      else cpu_idle();
      step();
      if (c == 0) begin
        aux_we = ~we; aux_reg = ~r; aux_wdata = ~wd;
        if (drop) aux_req = 1'b0;
      end
      if (aux_ack) begin
        ack_cyc = c + 1;
        aux_req = 1'b0;
      end
    end
    cpu_idle();
    step();
    check("ack_width", 32'(aux_ack), 32'd0);
    check("busy_after", 32'(aux_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   ack;
    int   acks;

    vecs[0] = '{we: 1'b1, drop: 1'b0, r: PORT_A, wd: 8'h06, exp_rd: 8'h00};
    vecs[1] = '{we: 1'b0, drop: 1'b0, r: PORT_A, wd: 8'h00, exp_rd: 8'h06};
    vecs[2] = '{we: 1'b1, drop: 1'b0, r: 4'd7,   wd: 8'h3F, exp_rd: 8'h06};
    vecs[3] = '{we: 1'b0, drop: 1'b0, r: 4'd7,   wd: 8'h00, exp_rd: 8'h3F};
    vecs[4] = '{we: 1'b1, drop: 1'b1, r: 4'd15,  wd: 8'hA5, exp_rd: 8'h3F};
    vecs[5] = '{we: 1'b0, drop: 1'b1, r: PORT_A, wd: 8'h00, exp_rd: 8'h06};

    cpu_idle();
    aux_req = 1'b0; aux_we = 1'b0; aux_reg = 4'h0; aux_wdata = 8'h00;
    #3;
    // CPU pass-through while reset is held, then idle pattern
    reset_n = 1'b0;
    cpu_read(A_DATA);
    #1;
    check("rst_pass", 32'({psg_sel, psg_ds, psg_rw, psg_addr}), 32'({1'b1, 1'b0, 1'b1, A_DATA}));
    cpu_idle();
    #1;
    check("rst_idle", 32'({psg_sel, psg_ds, psg_rw, psg_addr, psg_din}),
          32'({1'b0, 1'b1, 1'b1, 8'h00, 8'h00}));
    do_reset();

    // Uncontended accesses
    for (int i = 0; i < 6; i++) begin
      push_w(A_SEL, {4'h0, vecs[i].r});
      if (vecs[i].we) push_w(A_DATA, vecs[i].wd);
      else push_r(A_SEL, 1'b1, vecs[i].exp_rd);
      push_w(A_SEL, 8'h00);
      aux_txn(vecs[i].we, vecs[i].r, vecs[i].wd, vecs[i].drop, 32'h0, 32'h0, 8'h00, ack);
      check($sformatf("v%0d_ack_cyc", i), 32'(ack), 32'd4);
      check($sformatf("v%0d_rdata", i), 32'(aux_rdata), 32'(vecs[i].exp_rd));
      if (vecs[i].we) check($sformatf("v%0d_psg_reg", i), 32'(psg_regs[vecs[i].r]), 32'(vecs[i].wd));
      check($sformatf("v%0d_stalls", i), 32'(aux_stalls), 32'd0);
      check($sformatf("v%0d_q", i), 32'(exp_q.size()), 32'd0);
    end

    // CPU reads during cycles 2-3 of an aux write
    do_reset();
    push_w(A_SEL, 8'h0E);
    push_r(A_SEL, 1'b1, 8'h06);
    push_r(A_SEL, 1'b1, 8'h06);
    push_w(A_DATA, 8'h11);
    push_w(A_SEL, 8'h00);
    aux_txn(1'b1, PORT_A, 8'h11, 1'b0, 32'h0000_000C, 32'h0, 8'h00, ack);
    check("cpu_rd_ack_cyc", 32'(ack), 32'd6);
    check("cpu_rd_stalls", 32'(aux_stalls), 32'd2);
    check("cpu_rd_porta", 32'(psg_regs[PORT_A]), 32'h11);
    check("cpu_rd_q", 32'(exp_q.size()), 32'd0);

    // CPU select write during DATA re-issues the select
    do_reset();
    push_w(A_SEL, 8'h0E);
    push_w(A_SEL, 8'h07);
    push_w(A_SEL, 8'h0E);
    push_w(A_DATA, 8'h22);
    push_w(A_SEL, 8'h07);
    aux_txn(1'b1, PORT_A, 8'h22, 1'b0, 32'h0, 32'h0000_0004, 8'h07, ack);
    check("selwr_data_ack_cyc", 32'(ack), 32'd6);
    check("selwr_data_stalls", 32'(aux_stalls), 32'd1);
    check("selwr_data_porta", 32'(psg_regs[PORT_A]), 32'h22);
    check("selwr_data_latch", 32'(psg_latch), 32'd7);
    check("selwr_data_q", 32'(exp_q.size()), 32'd0);

    // CPU select write during SEL, then during RESTORE
    do_reset();
    push_w(A_SEL, 8'h05);
    push_w(A_SEL, 8'h0F);
    push_w(A_DATA, 8'h44);
    push_w(A_SEL, 8'h05);
    aux_txn(1'b1, PORT_B, 8'h44, 1'b0, 32'h0, 32'h0000_0002, 8'h05, ack);
    check("selwr_sel_ack_cyc", 32'(ack), 32'd5);
    check("selwr_sel_portb", 32'(psg_regs[PORT_B]), 32'h44);
    push_w(A_SEL, 8'h07);
    push_w(A_DATA, 8'h12);
    push_w(A_SEL, 8'h09);
    push_w(A_SEL, 8'h09);
    aux_txn(1'b1, 4'd7, 8'h12, 1'b0, 32'h0, 32'h0000_0008, 8'h09, ack);
    check("selwr_rst_ack_cyc", 32'(ack), 32'd5);
    check("selwr_rst_stalls", 32'(aux_stalls), 32'd2);
    check("selwr_rst_reg7", 32'(psg_regs[7]), 32'h12);
    check("selwr_rst_latch", 32'(psg_latch), 32'd9);
    check("selwr_q", 32'(exp_q.size()), 32'd0);

    // Reset pulsed during RESTORE
    do_reset();
    cpu_write(A_SEL, 8'h07);
    push_w(A_SEL, 8'h07);
    step();
    cpu_idle();
    check("pre_rst_stalls", 32'(aux_stalls), 32'd1);
    push_w(A_SEL, 8'h0E);
    push_w(A_DATA, 8'h33);
    aux_req = 1'b1; aux_we = 1'b1; aux_reg = PORT_A; aux_wdata = 8'h33;
    step();
    step();
    step();
    aux_req = 1'b0;
    check("pre_rst_busy", 32'(aux_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(aux_busy), 32'd0);
    check("mid_rst_stalls", 32'(aux_stalls), 32'd0);
    check("mid_rst_ack", 32'(aux_ack), 32'd0);
    #1;
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (aux_ack) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    check("mid_rst_porta", 32'(psg_regs[PORT_A]), 32'h33);
    push_w(A_SEL, 8'h0E);
    push_r(A_SEL, 1'b1, 8'h33);
    push_w(A_SEL, 8'h00);
    aux_txn(1'b0, PORT_A, 8'h00, 1'b0, 32'h0, 32'h0, 8'h00, ack);
    check("post_rst_ack_cyc", 32'(ack), 32'd4);
    check("post_rst_rdata", 32'(aux_rdata), 32'h33);
    check("post_rst_q", 32'(exp_q.size()), 32'd0);

    // Continuous CPU activity with a pending request
    do_reset();
    aux_req = 1'b1; aux_we = 1'b1; aux_reg = PORT_B; aux_wdata = 8'h5A;
    cpu_read(A_DATA);
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      push_r(A_DATA, 1'b0, 8'h00);
      step();
      if (aux_ack) acks++;
    end
    check("sat_no_ack", 32'(acks), 32'd0);
    check("sat_stalls", 32'(aux_stalls), 32'hFF);
    check("sat_busy", 32'(aux_busy), 32'd0);
    push_w(A_SEL, 8'h0F);
    push_w(A_DATA, 8'h5A);
    push_w(A_SEL, 8'h00);
    aux_txn(1'b1, PORT_B, 8'h5A, 1'b0, 32'h0, 32'h0, 8'h00, ack);
    check("sat_ack_cyc", 32'(ack), 32'd4);
    check("sat_stalls_hold", 32'(aux_stalls), 32'hFF);
    check("sat_portb", 32'(psg_regs[PORT_B]), 32'h5A);
    check("sat_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
